// File: rtl/lcd_serial_decoder.sv
// PCD8544 (Nokia 5110) serial bus receiver: decodes command/data bytes, tracks
// the controller's address/mode state and emits a byte-write stream for a shadow frame.
`timescale 1ns/1ps
module lcd_serial_decoder #(
  parameter int COLS  = 84,
  parameter int BANKS = 6,
  parameter int XW    = 7,
  parameter int YW    = 3,
  parameter int CW    = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              nRES,
  input  logic              SCLK,
  input  logic              SDIN,
  input  logic              DnC,
  input  logic              nSCE,
  output logic              wr_en,
  output logic [XW+YW-1:0]  wr_addr,
  output logic [7:0]        wr_data,
  output logic [XW-1:0]     cur_x,
  output logic [YW-1:0]     cur_y,
  output logic              power_down,
  output logic              vaddr,
  output logic              ext_instr,
  output logic [1:0]        disp_mode,
  output logic [CW-1:0]     data_count,
  output logic [CW-1:0]     cmd_count,
  output logic              proto_err,
  output logic [CW-1:0]     err_count
);
  localparam logic [7:0] COLS8  = 8'(COLS);
  localparam logic [7:0] BANKS8 = 8'(BANKS);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [1:0] nres_q, sclk_q, sdin_q, dnc_q, nsce_q;
  logic       sclk_d;
  logic       nres_ok, rise, nsce;

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      nres_q <= '0; sclk_q <= '0; sdin_q <= '0; dnc_q <= '0; nsce_q <= '0; sclk_d <= 1'b0;
    end else begin
      nres_q <= {nres_q[0], nRES};
      sclk_q <= {sclk_q[0], SCLK};
      sdin_q <= {sdin_q[0], SDIN};
      dnc_q  <= {dnc_q[0],  DnC};
      nsce_q <= {nsce_q[0], nSCE};
      sclk_d <= sclk_q[1];
    end

  assign nres_ok = nres_q[1];
  assign rise    = sclk_q[1] & ~sclk_d;
  assign nsce    = nsce_q[1];

  state_t     state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] sh, byte_r;
  logic       dc_r, byte_vld;
  logic       shift_en, done, abort;

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset)       state <= IDLE;
    else if (!nres_ok) state <= IDLE;
    else               state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!nsce) state_nx = SHIFT;
      SHIFT:   if (nsce)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A last bit seen together with nSCE rising still completes the byte.
  always_comb begin
    shift_en = (state == SHIFT) && rise && (!nsce || bit_cnt == 3'd7);
    done     = shift_en && (bit_cnt == 3'd7);
    abort    = (state == SHIFT) && nsce && (bit_cnt != 3'd0) && !done;
  end

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      bit_cnt <= '0; sh <= '0; byte_r <= '0; dc_r <= 1'b0; byte_vld <= 1'b0;
    end else if (!nres_ok) begin
      bit_cnt <= '0; sh <= '0; byte_r <= '0; dc_r <= 1'b0; byte_vld <= 1'b0;
    end else begin
      byte_vld <= done;
      if (shift_en) begin
        sh      <= {sh[6:0], sdin_q[1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state == IDLE || nsce) begin
        bit_cnt <= '0;
      end
      if (done) begin
        byte_r <= {sh[6:0], sdin_q[1]};
        dc_r   <= dnc_q[1];
      end
    end

  logic is_data, is_cmd;
  logic c_nop, c_fs, c_dm, c_y, c_x, c_h1, y_ok, x_ok, cmd_err;

  always_comb begin
    is_data = byte_vld && dc_r;
    is_cmd  = byte_vld && !dc_r;
    c_nop   = byte_r == 8'h00;
    c_fs    = byte_r[7:5] == 3'b001;
    c_dm    = !ext_instr && byte_r[7:3] == 5'b00001 && !byte_r[1];
    c_y     = !ext_instr && byte_r[7:3] == 5'b01000;
    c_x     = !ext_instr && byte_r[7];
    c_h1    = ext_instr && (byte_r[7:2] == 6'b000001 || byte_r[7:3] == 5'b00010 || byte_r[7]);
    y_ok    = {5'd0, byte_r[2:0]} < BANKS8;
    x_ok    = {1'b0, byte_r[6:0]} < COLS8;
    cmd_err = is_cmd && !(c_nop || c_fs || c_dm || (c_y && y_ok) || (c_x && x_ok) || c_h1);
  end

  logic [XW-1:0] x_nx;
  logic [YW-1:0] y_nx;
  logic          x_end, y_end;

  always_comb begin
    x_end = cur_x == XW'(COLS - 1);
    y_end = cur_y == YW'(BANKS - 1);
    if (!vaddr) begin
      x_nx = x_end ? '0 : cur_x + XW'(1);
      y_nx = x_end ? (y_end ? '0 : cur_y + YW'(1)) : cur_y;
    end else begin
      y_nx = y_end ? '0 : cur_y + YW'(1);
      x_nx = y_end ? (x_end ? '0 : cur_x + XW'(1)) : cur_x;
    end
  end

  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; cur_x <= '0; cur_y <= '0;
      power_down <= 1'b1; vaddr <= 1'b0; ext_instr <= 1'b0; disp_mode <= '0;
    end else if (!nres_ok) begin
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; cur_x <= '0; cur_y <= '0;
      power_down <= 1'b1; vaddr <= 1'b0; ext_instr <= 1'b0; disp_mode <= '0;
    end else begin
      wr_en <= is_data;
      if (is_data) begin
        wr_addr <= {cur_y, cur_x};
        wr_data <= byte_r;
      end
      // Address advances in the cycle after the write strobe.
      if (wr_en) begin
        cur_x <= x_nx;
        cur_y <= y_nx;
      end else if (is_cmd) begin
        if (c_fs) {power_down, vaddr, ext_instr} <= byte_r[2:0];
        if (c_dm) disp_mode <= {byte_r[2], byte_r[0]};
        if (c_y && y_ok) cur_y <= YW'(byte_r[2:0]);
        if (c_x && x_ok) cur_x <= XW'(byte_r[6:0]);
      end
    end

  // Statistics survive the bus nRES; only nReset clears them.
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      data_count <= '0; cmd_count <= '0; err_count <= '0; proto_err <= 1'b0;
    end else if (nres_ok) begin
      if (is_data && data_count != '1) data_count <= data_count + CW'(1);
      if (is_cmd && cmd_count != '1)   cmd_count  <= cmd_count + CW'(1);
      if (abort || cmd_err) begin
        proto_err <= 1'b1;
        if (err_count != '1) err_count <= err_count + CW'(1);
      end
    end
endmodule

// File: tb/tb_lcd_serial_decoder.sv
// Scoreboarded bench for lcd_serial_decoder: bit-bangs the PCD8544 bus and
// checks the write stream plus address/mode/counter state.
`timescale 1ns/1ps
module tb_lcd_serial_decoder;
  logic        Clock = 1'b0, nReset = 1'b0;
  logic        nRES = 1'b1, SCLK = 1'b0, SDIN = 1'b0, DnC = 1'b0, nSCE = 1'b1;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [2:0]  cur_y;
  logic        power_down, vaddr, ext_instr, proto_err;
  logic [1:0]  disp_mode;
  logic [15:0] data_count, cmd_count, err_count;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic        wr_prev = 1'b0;

  lcd_serial_decoder dut (
    .Clock(Clock), .nReset(nReset), .nRES(nRES), .SCLK(SCLK), .SDIN(SDIN), .DnC(DnC),
    .nSCE(nSCE), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_x(cur_x),
    .cur_y(cur_y), .power_down(power_down), .vaddr(vaddr), .ext_instr(ext_instr),
    .disp_mode(disp_mode), .data_count(data_count), .cmd_count(cmd_count),
    .proto_err(proto_err), .err_count(err_count)
  );

  always #10 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wv(input int y, input int x, input int d);
    return (y << 15) | (x << 8) | d;
  endfunction

  always @(negedge Clock) begin
    if (wr_en && wr_prev) chk("wr_pulse", 32'd2, 32'd1);
    if (wr_en) begin
      if (exp_q.size() == 0) chk("wr_unexpected", {14'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else chk("wr", {14'd0, wr_addr, wr_data}, exp_q.pop_front());
    end
    wr_prev <= wr_en;
  end

  task automatic send(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) begin
      SDIN = b[i]; DnC = dc; SCLK = 1'b0;
      #200;
      SCLK = 1'b1;
      #200;
    end
    SCLK = 1'b0;
  endtask

  task automatic data(input logic [7:0] b, input int y, input int x);
    exp_q.push_back(wv(y, x, b));
    send(b, 1'b1);
  endtask

  task automatic idle(input int n);
    #200; nSCE = 1'b1;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    repeat (5) @(posedge Clock);
    #3 nReset = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    chk("rst_pd", power_down, 1);
    chk("rst_mode", {vaddr, ext_instr, disp_mode}, 0);
    chk("rst_xy", {cur_y, cur_x}, 0);
    chk("rst_cnt", {proto_err, data_count, cmd_count}, 0);
    chk("rst_wr", {wr_en, err_count}, 0);

    nSCE = 1'b0;
    send(8'h21, 0); send(8'h20, 0); send(8'h0C, 0); send(8'h45, 0); send(8'h8A, 0);
    idle(10);
    chk("fs_bits", {power_down, vaddr, ext_instr}, 0);
    chk("disp_norm", disp_mode, 2'b10);
    chk("set_y", cur_y, 5);
    chk("set_x", cur_x, 10);
    chk("cmd_cnt5", cmd_count, 5);
    nSCE = 1'b0;
    data(8'hA5, 5, 10);
    idle(10);
    chk("adv_x", {cur_y, cur_x}, {3'd5, 7'd11});
    chk("data_cnt1", data_count, 1);

    nSCE = 1'b0;
    send(8'hD3, 0); send(8'h45, 0);
    data(8'h11, 5, 83); data(8'h22, 0, 0);
    idle(10);
    chk("hwrap", {cur_y, cur_x}, {3'd0, 7'd1});

    nSCE = 1'b0;
    send(8'h22, 0); send(8'hD3, 0); send(8'h44, 0);
    data(8'h33, 4, 83); data(8'h44, 5, 83); data(8'h55, 0, 0);
    send(8'h20, 0);
    idle(10);
    chk("vwrap", {cur_y, cur_x}, {3'd1, 7'd0});
    chk("vmode_off", vaddr, 0);
    chk("data_cnt6", data_count, 6);

    nSCE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SDIN = i[0]; SCLK = 1'b0; #200; SCLK = 1'b1; #200;
    end
    SCLK = 1'b0;
    idle(10);
    nSCE = 1'b0;
    send(8'h80, 0);
    idle(10);
    chk("abort_err", {proto_err, err_count}, {1'b1, 16'd1});
    chk("abort_x", cur_x, 0);
    chk("cmd_cnt12", cmd_count, 12);

    nSCE = 1'b0;
    send(8'h47, 0);
    idle(10);
    chk("bad_y_err", err_count, 2);
    chk("bad_y_keep", cur_y, 1);
    nSCE = 1'b0;
    send(8'h85, 0);
    data(8'h3C, 1, 5);
    idle(10);
    chk("pre_res", {cur_y, cur_x}, {3'd1, 7'd6});
    nRES = 1'b0;
    repeat (10) @(posedge Clock);
    #1 nRES = 1'b1;
    repeat (5) @(posedge Clock);
    #1;
    chk("res_xy", {cur_y, cur_x}, 0);
    chk("res_pd", {power_down, disp_mode}, {1'b1, 2'b00});
    chk("res_cnt", {data_count, cmd_count}, {16'd7, 16'd14});
    chk("res_err", {proto_err, err_count}, {1'b1, 16'd2});

    nSCE = 1'b0;
    send(8'h0D, 0); send(8'h21, 0); send(8'hC8, 0);
    idle(10);
    chk("disp_inv", disp_mode, 2'b11);
    chk("h1_vop", {ext_instr, cur_x, err_count}, {1'b1, 7'd0, 16'd2});
    nSCE = 1'b0;
    send(8'h20, 0); send(8'hD4, 0);
    idle(10);
    chk("bad_x", {cur_x, err_count}, {7'd0, 16'd3});
    chk("cmd_cnt19", cmd_count, 19);
    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
